// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - command encodings, FSM state type and default widths for the SDRAM burst arbiter
package sdram_arb_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam int DEF_ASIZE = 23;
  localparam int DEF_LSIZE = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY
  } arb_state_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// rtl/sdram_rr_pick.sv - combinational round-robin picker: first eligible port at or after ptr, wrapping
module sdram_rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] elig,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] win_oh,
  output logic                 win_valid
);

  always_comb begin
    int p;
    int rank;
    win_oh    = '0;
    win_valid = 1'b0;
    p         = int'(ptr);
    rank      = 0;
    // Visit ports in scan order k = 0..N-1; rank is the port's distance from ptr.
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rank = (i >= p) ? (i - p) : (i + NUM_PORTS - p);
        if (!win_valid && elig[i] && (rank == k)) begin
          win_oh[i] = 1'b1;
          win_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// rtl/sdram_burst_arbiter.sv - round-robin arbiter sharing one SDRAM command port among burst requesters
// Optional write-priority scan enabled by defining SDRAM_ARB_WR_PRIO_EN.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int LSIZE     = DEF_LSIZE,
  parameter int TIMEOUT   = 1023
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_PORTS-1:0]       REQ,
  input  logic [NUM_PORTS-1:0]       REQ_WR,
  input  logic [NUM_PORTS*ASIZE-1:0] REQ_ADDR,
  input  logic [NUM_PORTS*LSIZE-1:0] REQ_LEN,
  output logic [NUM_PORTS-1:0]       GNT,
  output logic [NUM_PORTS-1:0]       PORT_DONE,
  output logic [NUM_PORTS-1:0]       PORT_ERR,
  output logic [1:0]                 CMD,
  output logic [ASIZE-1:0]           ADDR,
  output logic [LSIZE-1:0]           LENGTH,
  input  logic                       CMD_ACK,
  input  logic                       BURST_DONE,
  output logic                       BUSY
);

  localparam int         PW  = $clog2(NUM_PORTS);
  localparam logic [9:0] TMO = 10'(TIMEOUT);

  arb_state_t           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        next_ptr;
  logic [PW-1:0]        pick_idx;
  logic [NUM_PORTS-1:0] cur_oh;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] pick_oh;
  logic                 pick_valid;
  logic [ASIZE-1:0]     sel_addr;
  logic [LSIZE-1:0]     sel_len;
  logic                 sel_wr;
  logic [9:0]           tmo_cnt;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      elig[i] = REQ[i] && (REQ_LEN[i*LSIZE +: LSIZE] != '0);
  end

`ifdef SDRAM_ARB_WR_PRIO_EN
  assign cand = (|(elig & REQ_WR)) ? (elig & REQ_WR) : elig;
`else
  assign cand = elig;
`endif

  sdram_rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .PW       (PW)
  ) u_pick (
    .elig     (cand),
    .ptr      (ptr),
    .win_oh   (pick_oh),
    .win_valid(pick_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_wr   = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_oh[i]) begin
        sel_addr = REQ_ADDR[i*ASIZE +: ASIZE];
        sel_len  = REQ_LEN[i*LSIZE +: LSIZE];
        sel_wr   = REQ_WR[i];
        pick_idx = PW'(i);
      end
    end
    next_ptr = (pick_idx == PW'(NUM_PORTS - 1)) ? '0 : pick_idx + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cur_oh    <= '0;
      tmo_cnt   <= '0;
      GNT       <= '0;
      PORT_DONE <= '0;
      PORT_ERR  <= '0;
      CMD       <= CMD_IDLE;
      ADDR      <= '0;
      LENGTH    <= '0;
      BUSY      <= 1'b0;
    end else begin
      GNT       <= '0;
      PORT_DONE <= '0;
      PORT_ERR  <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            ADDR   <= sel_addr;
            LENGTH <= sel_len;
            CMD    <= sel_wr ? CMD_WRITE : CMD_READ;
            GNT    <= pick_oh;
            cur_oh <= pick_oh;
            ptr    <= next_ptr;
            BUSY   <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (CMD_ACK) begin
            CMD     <= CMD_IDLE;
            tmo_cnt <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A completion in the same cycle as the timeout still counts as success.
          if (BURST_DONE) begin
            PORT_DONE <= cur_oh;
            BUSY      <= 1'b0;
            state     <= ST_IDLE;
          end else if (tmo_cnt == TMO) begin
            PORT_ERR <= cur_oh;
            BUSY     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_burst_arbiter.md
# sdram_burst_arbiter

Round-robin arbiter that shares one SDRAM controller command port among NUM_PORTS burst requesters (video write, frame read, CPU DMA and similar). Each requester posts a read or write burst descriptor: address plus length. The arbiter selects one, drives the controller's CMD/ADDR/LENGTH handshake, waits for burst completion, then returns a per-port done pulse. It sits between the client FIFO logic and the SDRAM command/control interface, and replaces the fixed write-then-read selection logic.

## Interface
- NUM_PORTS, 4: number of requesters, 2..8.
- ASIZE, 23: SDRAM word address width.
- LSIZE, 9: burst length width.
- TIMEOUT, 1023: cycles allowed in BUSY before abort; 10-bit counter.
- CLK  in  1  controller clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  NUM_PORTS  per-port burst request, level.
- REQ_WR  in  NUM_PORTS  1 = write burst, 0 = read burst.
- REQ_ADDR  in  NUM_PORTS*ASIZE  packed start addresses; port i at [i*ASIZE +: ASIZE].
- REQ_LEN  in  NUM_PORTS*LSIZE  packed burst lengths.
- GNT  out  NUM_PORTS  one-cycle grant pulse, one-hot.
- PORT_DONE  out  NUM_PORTS  one-cycle completion pulse to the granted port.
- PORT_ERR  out  NUM_PORTS  one-cycle timeout pulse to the granted port.
- CMD  out  2  to controller: 00 idle, 01 read, 10 write.
- ADDR  out  ASIZE  latched burst address.
- LENGTH  out  LSIZE  latched burst length.
- CMD_ACK  in  1  controller accepted CMD.
- BURST_DONE  in  1  controller one-cycle burst-complete pulse.
- BUSY  out  1  high from grant until return to IDLE.

## Operation
- States: IDLE, ISSUE, BUSY.
- IDLE:
  - Eligible port: REQ[i]=1 and REQ_LEN slice ≠ 0. Ports with zero length are never granted.
  - Winner: first eligible port at or after PTR, scanning upward modulo NUM_PORTS.
  - With an eligible port present: latch the winner's ADDR/LENGTH/direction, pulse GNT[winner], set CMD, set PTR = (winner+1) mod NUM_PORTS, go to ISSUE.
- ISSUE:
  - CMD is held until CMD_ACK is sampled high.
  - Next cycle: CMD=00, go to BUSY, clear the timeout counter.
- BUSY:
  - BURST_DONE sampled high: pulse PORT_DONE[winner], go to IDLE.
  - Counter reaches TIMEOUT: pulse PORT_ERR[winner], go to IDLE. PTR has already advanced.
- Clients keep descriptor fields stable while REQ is high. They may drop REQ once GNT is seen, or keep it high for the next burst. A kept-high REQ is re-arbitrated fairly.
- CMD_ACK and BURST_DONE are ignored outside ISSUE and BUSY respectively.
- BURST_DONE in ISSUE together with CMD_ACK is ignored (protocol violation). The timeout then recovers.
- No FIFO-level checks: the clients decide when to request.

## Timing
- Reset values:
  - CMD=00, ADDR=0, LENGTH=0, GNT=0, PORT_DONE=0, PORT_ERR=0, BUSY=0.
  - PTR=0, state IDLE, timeout counter=0.
- Reset mid-burst: return to IDLE at once, with no done or error pulse.
- Request latency: REQ high at edge t → GNT, CMD, ADDR, LENGTH, BUSY valid after edge t+1 (registered outputs).
- CMD_ACK high at edge a → CMD=00 after edge a+1.
- BURST_DONE at edge d → PORT_DONE after edge d+1, BUSY low after edge d+1.
- Next grant earliest after edge d+2, giving one idle cycle between bursts.
- Timeout: PORT_ERR asserts TIMEOUT+1 cycles after entry to BUSY.
- Simultaneous BURST_DONE and timeout in the same cycle: BURST_DONE wins, and PORT_ERR stays low.

## Configuration
- SDRAM_ARB_WR_PRIO_EN:
  - Defined: in IDLE, if any eligible write request exists, the round-robin scan considers only write requests. Reads are granted only when no eligible write exists. PTR updates as normal.
  - Undefined: pure round-robin regardless of direction.

## Structure
- Package sdram_arb_pkg holds:
  - CMD encodings CMD_IDLE, CMD_READ, CMD_WRITE.
  - State enum for IDLE/ISSUE/BUSY.
  - Default widths for ASIZE and LSIZE.
- Sub-module sdram_rr_pick: combinational round-robin picker. Inputs are the eligibility vector and PTR; outputs are the one-hot winner and a valid flag. Instantiated once, with the write-only mask applied ahead of it when SDRAM_ARB_WR_PRIO_EN is set.

## Test plan
- Single port 0 write, ADDR=0x000100, LEN=256:
  - GNT=0001 one cycle after REQ, CMD=10 until CMD_ACK.
  - PORT_DONE[0] one cycle after BURST_DONE.
- Ports 0–3 all requesting continuously: grant order 0,1,2,3,0,1. Each port gets exactly one grant per four bursts.
- Port 2 with REQ_LEN=0 and port 3 valid, PTR=2: port 3 granted and port 2 never granted.
- BURST_DONE withheld, TIMEOUT=15: PORT_ERR pulses 16 cycles after BUSY entry, then state returns to IDLE and the next port is granted.
- RESET asserted during BUSY: the next cycle shows all outputs at reset values, and no PORT_DONE is emitted.
- With SDRAM_ARB_WR_PRIO_EN, port 0 read and port 1 write both requesting, PTR=0:
  - Port 1 granted first.
  - Without the macro, port 0 is granted first.
